// File: rtl/spi_mnrch_pkg.sv
// Shared types for the SPI monarch: FSM state encoding, SPI mode struct and mode constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package spi_mnrch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  // Packed so that {cpol, cpha} lines up with the 2-bit mode port (cpol is the MSB).
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: owns the registered SCLK and decodes edge strobes from the FSM's counters.
// Latency: lead_edge/trail_edge are combinational, one cycle ahead of the registered SCLK toggle.
// Backpressure: none; counters only advance under FSM control.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   run           FSM is in SETUP or XFER (edges may be issued)
//   load          transfer accepted this cycle; SCLK takes load_cpol next cycle
//   load_cpol     CPOL of the transfer being accepted
//   div_cnt       half-period divider count (0..H-1)
//   edge_cnt      number of SCLK edges already issued
//   sclk          registered serial clock
//   lead_edge     next clock edge is a leading (odd-numbered) SCLK edge
//   trail_edge    next clock edge is a trailing (even-numbered) SCLK edge
//   last_edge     all 2*DATA_W edges have been issued
module spi_sclk_gen #(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 16,
  parameter int DIV_W    = $clog2(SCLK_DIV / 2) + 1,
  parameter int EDGE_W   = $clog2(2 * DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load,
  input  logic              load_cpol,
  input  logic [DIV_W-1:0]  div_cnt,
  input  logic [EDGE_W-1:0] edge_cnt,
  output logic              sclk,
  output logic              lead_edge,
  output logic              trail_edge,
  output logic              last_edge
);

  localparam int H     = SCLK_DIV / 2;
  localparam int EDGES = 2 * DATA_W;

  logic sclk_q, sclk_d;
  logic edge_due;

  always_comb begin
    // An edge is due at the end of every half period while edges remain.
    edge_due   = run && (div_cnt == DIV_W'(H - 1)) && (edge_cnt < EDGE_W'(EDGES));
    // edge_cnt even means the upcoming edge number (edge_cnt+1) is odd, i.e. leading.
    lead_edge  = edge_due && !edge_cnt[0];
    trail_edge = edge_due && edge_cnt[0];
    last_edge  = (edge_cnt == EDGE_W'(EDGES));

    sclk_d = sclk_q;
    if (load) begin
      sclk_d = load_cpol;
    end else if (edge_due) begin
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b1;
    end else begin
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_mnrch_multi.sv
// SPI monarch with NUM_SS selects, DATA_W-bit full-duplex word, per-transfer CPOL/CPHA.
// Latency: wrt accepted at cycle 0 -> done at cycle DATA_W*SCLK_DIV + SCLK_DIV + 1.
// Backpressure: wrt is only taken in IDLE (busy low); wrt while busy is dropped, not queued.
//
// Build option: define SPI_MNRCH_LSB_FIRST_EN to add the lsb_first input (LSB-first shifting).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wrt           start pulse, sampled only in IDLE
//   wt_data       word to transmit
//   ss_sel        target slave index (out-of-range -> no select asserted)
//   mode          {CPOL, CPHA}, latched on accepted wrt
//   lsb_first     (optional) shift LSB first, latched on accepted wrt
//   MISO          serial data from slave
//   SS_n          registered active-low selects
//   SCLK          registered serial clock
//   MOSI          registered serial data to slave
//   busy          transfer in progress
//   done          sticky completion flag, cleared by the next accepted wrt
//   rd_data       received word
module spi_mnrch_multi
  import spi_mnrch_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 16,
  parameter int NUM_SS   = 1,
  parameter int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wt_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [1:0]        mode,
`ifdef SPI_MNRCH_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int H      = SCLK_DIV / 2;
  localparam int DIV_W  = $clog2(H) + 1;
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

  spi_state_t        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              mosi_q, mosi_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              cpha_q, cpha_d;
`ifdef SPI_MNRCH_LSB_FIRST_EN
  logic              lsb_q, lsb_d;
`endif

  spi_mode_t         mode_s;
  logic              accept;
  logic              run;
  logic              div_wrap;
  logic              lead_edge, trail_edge, last_edge;
  logic              tx_bit;
  logic [DATA_W-1:0] sr_shift;
  logic              first_bit;

  assign mode_s = spi_mode_t'(mode);
  assign run    = (state_q == ST_SETUP) || (state_q == ST_XFER);

  spi_sclk_gen #(
    .DATA_W   (DATA_W),
    .SCLK_DIV (SCLK_DIV),
    .DIV_W    (DIV_W),
    .EDGE_W   (EDGE_W)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .load       (accept),
    .load_cpol  (mode_s.cpol),
    .div_cnt    (div_q),
    .edge_cnt   (edge_q),
    .sclk       (SCLK),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    sr_d      = sr_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = done_q;
    rd_data_d = rd_data_q;
    cpha_d    = cpha_q;
    accept    = 1'b0;
    div_wrap  = (div_q == DIV_W'(H - 1));

    // One shift register serves both directions: the outgoing bit leaves one end
    // while MISO enters the other, so after DATA_W samples it holds the received word.
`ifdef SPI_MNRCH_LSB_FIRST_EN
    lsb_d     = lsb_q;
    tx_bit    = lsb_q ? sr_q[0] : sr_q[DATA_W-1];
    sr_shift  = lsb_q ? {MISO, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], MISO};
    first_bit = lsb_first ? wt_data[0] : wt_data[DATA_W-1];
`else
    tx_bit    = sr_q[DATA_W-1];
    sr_shift  = {sr_q[DATA_W-2:0], MISO};
    first_bit = wt_data[DATA_W-1];
`endif

    case (state_q)
      ST_IDLE: begin
        if (wrt) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
          sr_d    = wt_data;
          cpha_d  = mode_s.cpha;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          edge_d  = '0;
`ifdef SPI_MNRCH_LSB_FIRST_EN
          lsb_d   = lsb_first;
`endif
          // Out-of-range selects leave every SS_n high; the transfer still runs.
          ss_n_d = '1;
          for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SS_W'(i)) begin
              ss_n_d[i] = 1'b0;
            end
          end
          // CPHA=0 slaves sample on the first edge, so the first bit must be
          // on the line for the whole SETUP half period.
          if (!mode_s.cpha) begin
            mosi_d = first_bit;
          end
        end
      end
      ST_SETUP: begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // Stays one extra half period after the final edge so SCLK rests at CPOL
        // for a full half period before HOLD begins.
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap && last_edge) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          state_d   = ST_IDLE;
          ss_n_d    = '1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          rd_data_d = sr_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (lead_edge || trail_edge) begin
      edge_d = edge_q + EDGE_W'(1);
    end
    // CPHA selects which edge samples MISO; MOSI moves on the other one.
    if (cpha_q ? trail_edge : lead_edge) begin
      sr_d = sr_shift;
    end
    if (cpha_q ? lead_edge : trail_edge) begin
      mosi_d = tx_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      sr_q      <= '0;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      cpha_q    <= 1'b0;
`ifdef SPI_MNRCH_LSB_FIRST_EN
      lsb_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      sr_q      <= sr_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      cpha_q    <= cpha_d;
`ifdef SPI_MNRCH_LSB_FIRST_EN
      lsb_q     <= lsb_d;
`endif
    end
  end

  assign SS_n    = ss_n_q;
  assign MOSI    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_spi_mnrch_multi.sv
// Bench for spi_mnrch_multi: default instance with a slave model, small 4-select instance in loopback.
// Latency: checks wrt-to-done cycle counts (273 and 37).
// Backpressure: checks that wrt while busy is ignored.
module tb_spi_mnrch_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- instance A: defaults (16-bit, div 16, one select) ----------------
  logic        a_wrt, a_miso, a_sclk, a_mosi, a_busy, a_done, a_loop;
  logic [15:0] a_wt, a_rd;
  logic [0:0]  a_sel, a_ss_n;
  logic [1:0]  a_mode;
`ifdef SPI_MNRCH_LSB_FIRST_EN
  logic        a_lsb, b_lsb;
`endif

  spi_mnrch_multi u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt       (a_wrt),
    .wt_data   (a_wt),
    .ss_sel    (a_sel),
    .mode      (a_mode),
`ifdef SPI_MNRCH_LSB_FIRST_EN
    .lsb_first (a_lsb),
`endif
    .MISO      (a_miso),
    .SS_n      (a_ss_n),
    .SCLK      (a_sclk),
    .MOSI      (a_mosi),
    .busy      (a_busy),
    .done      (a_done),
    .rd_data   (a_rd)
  );

  // ---------------- instance B: 8-bit, div 4, four selects, loopback ----------------
  logic       b_wrt, b_sclk, b_mosi, b_busy, b_done;
  logic [7:0] b_wt, b_rd;
  logic [2:0] b_sel;
  logic [3:0] b_ss_n;
  logic [1:0] b_mode;

  spi_mnrch_multi #(.DATA_W(8), .SCLK_DIV(4), .NUM_SS(4), .SS_W(3)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt       (b_wrt),
    .wt_data   (b_wt),
    .ss_sel    (b_sel),
    .mode      (b_mode),
`ifdef SPI_MNRCH_LSB_FIRST_EN
    .lsb_first (b_lsb),
`endif
    .MISO      (b_mosi),
    .SS_n      (b_ss_n),
    .SCLK      (b_sclk),
    .MOSI      (b_mosi),
    .busy      (b_busy),
    .done      (b_done),
    .rd_data   (b_rd)
  );

  // ---------------- slave model for A (runs on negedge, away from DUT edges) ----------------
  logic [15:0] s_tx, s_rx;
  logic        s_miso = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
  logic        s_prev_sclk = 1'b1, s_prev_ss = 1'b1, s_lead;
  int          s_idx = 0, s_edges = 0;

  assign a_miso = a_loop ? a_mosi : s_miso;

  always @(negedge clk) begin
    if (!a_ss_n[0]) begin
      if (s_prev_ss) begin
        s_idx = 0; s_edges = 0; s_rx = '0;
        if (!s_cpha) begin s_miso = s_tx[15]; s_idx = 1; end
      end else if (a_sclk != s_prev_sclk) begin
        s_edges++;
        s_lead = (a_sclk != s_cpol);
        if (s_lead ^ s_cpha) begin
          s_rx = {s_rx[14:0], a_mosi};
        end else begin
          if (s_idx < 16) s_miso = s_tx[15 - s_idx];
          s_idx++;
        end
      end
    end
    s_prev_sclk = a_sclk;
    s_prev_ss   = a_ss_n[0];
  end

  // ---------------- scoreboards: push on wrt, pop on done rising ----------------
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic        a_done_p = 1'b0, b_done_p = 1'b0;

  always @(negedge clk) begin
    if (a_done && !a_done_p) begin
      if (a_q.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
      else check("a_rd_data", {16'h0, a_rd}, a_q.pop_front());
    end
    if (b_done && !b_done_p) begin
      if (b_q.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
      else check("b_rd_data", {24'h0, b_rd}, b_q.pop_front());
    end
    a_done_p = a_done;
    b_done_p = b_done;
  end

  // One transfer on A. poke: re-pulse wrt mid-transfer and on the final HOLD cycle.
  task automatic run_a(input logic [15:0] data, input logic [1:0] mode, input logic [15:0] echo,
                       input logic [15:0] exp_rd, input logic [15:0] exp_stream, input bit poke);
    int base, rel, lat, ss_low;
    @(negedge clk);
    s_tx = echo; s_cpol = mode[1]; s_cpha = mode[0];
    a_wt = data; a_mode = mode; a_sel = 1'b0; a_wrt = 1'b1;
    base = cyc;
    a_q.push_back({16'h0, exp_rd});
    lat = -1; ss_low = 0;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      @(negedge clk);
      rel   = cyc - base;
      a_wrt = poke && (rel == 100 || rel == 272);
      if (poke && rel == 100) a_wt = 16'hFFFF;
      if (poke && rel == 101) check("a_busy_after_ignored_wrt", a_busy, 1);
      if (rel == 1) begin
        check("a_ss_low_at_1", a_ss_n[0], 0);
        check("a_sclk_cpol_at_1", a_sclk, mode[1]);
        if (!mode[0]) check("a_mosi_first_bit", a_mosi, exp_stream[15]);
      end
      if (!a_ss_n[0]) ss_low++;
      if (a_done) lat = rel;
    end
    a_wrt = 1'b0;
    check("a_latency", lat, 273);
    check("a_ss_low_cycles", ss_low, 272);
    check("a_mosi_stream", s_rx, exp_stream);
    check("a_sclk_edges", s_edges, 32);
    check("a_busy_at_done", a_busy, 0);
    check("a_ss_high_at_done", a_ss_n[0], 1);
    if (poke) begin
      @(negedge clk);
      check("a_wrt_on_done_ignored", a_busy, 0);
      check("a_ss_high_after_done", a_ss_n[0], 1);
    end
  endtask

  // One loopback transfer on B.
  task automatic run_b(input logic [7:0] data, input logic [1:0] mode, input logic [2:0] sel,
                       input logic [3:0] exp_ss);
    int base, rel, lat, edges;
    logic [3:0] ss_and;
    logic prev, mosi0;
    @(negedge clk);
    mosi0 = b_mosi;
    b_wt = data; b_mode = mode; b_sel = sel; b_wrt = 1'b1;
    base = cyc;
    b_q.push_back({24'h0, data});
    lat = -1; edges = 0; ss_and = 4'hF; prev = b_sclk;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      b_wrt = 1'b0;
      rel = cyc - base;
      if (rel == 1) begin
        check("b_sclk_cpol_at_1", b_sclk, mode[1]);
        check("b_mosi_at_1", b_mosi, mode[0] ? mosi0 : data[7]);
      end else if (b_sclk != prev) begin
        edges++;
      end
      // Edge 2 (cycle 5) is trailing: MOSI moves there only for CPHA=0.
      if (rel == 5) check("b_mosi_after_edge2", b_mosi, mode[0] ? data[7] : data[6]);
      prev   = b_sclk;
      ss_and = ss_and & b_ss_n;
      if (b_done) lat = rel;
    end
    check("b_latency", lat, 37);
    check("b_ss_asserted", ss_and, exp_ss);
    check("b_sclk_edges", edges, 16);
    check("b_sclk_idle_cpol", b_sclk, mode[1]);
    check("b_busy_at_done", b_busy, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    a_wrt = 1'b0; a_wt = '0; a_sel = '0; a_mode = 2'b00; a_loop = 1'b0; s_tx = '0; s_rx = '0;
    b_wrt = 1'b0; b_wt = '0; b_sel = '0; b_mode = 2'b00;
`ifdef SPI_MNRCH_LSB_FIRST_EN
    a_lsb = 1'b0; b_lsb = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ss_n", a_ss_n, 1);
    check("rst_sclk", a_sclk, 1);
    check("rst_mosi", a_mosi, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rd_data", a_rd, 0);
    check("rst_b_ss_n", b_ss_n, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 3, slave echoes 3C5A; wrt during XFER and on the final HOLD cycle must be ignored.
    run_a(16'hA5C3, 2'b11, 16'h3C5A, 16'h3C5A, 16'hA5C3, 1'b1);

    // Reset around bit 7 of a mode-0 transfer.
    @(negedge clk);
    s_tx = 16'h1234; s_cpol = 1'b0; s_cpha = 1'b0;
    a_mode = 2'b00; a_wt = 16'hBEEF; a_wrt = 1'b1;
    base = cyc;
    a_q.push_back(32'h1234);
    @(negedge clk);
    a_wrt = 1'b0;
    while (cyc - base < 121) @(negedge clk);
    check("pre_rst_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss_n", a_ss_n, 1);
    check("abort_sclk", a_sclk, 1);
    check("abort_done", a_done, 0);
    check("abort_busy", a_busy, 0);
    a_q.delete();
    b_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    run_a(16'h5AF0, 2'b00, 16'hC3A5, 16'hC3A5, 16'h5AF0, 1'b0);

    run_b(8'h96, 2'b00, 3'd2, 4'b1011);
    run_b(8'h96, 2'b01, 3'd2, 4'b1011);
    run_b(8'h96, 2'b10, 3'd2, 4'b1011);
    run_b(8'h96, 2'b00, 3'd5, 4'b1111);

`ifdef SPI_MNRCH_LSB_FIRST_EN
    a_lsb = 1'b1; a_loop = 1'b1;
    run_a(16'h0001, 2'b00, 16'h0000, 16'h0001, 16'h8000, 1'b0);
    a_lsb = 1'b0; a_loop = 1'b0;
`endif

    @(negedge clk);
    check("scoreboard_drained", a_q.size() + b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
